// File: rtl/soundweb_pkg.sv
// soundweb_pkg: framing constants, packet lengths and decoder state encoding
package soundweb_pkg;
  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [7:0] ESC_OFFSET = 8'h80;
  localparam int BODY_LEN = 13;
  localparam int PKT_LEN = 14;
  typedef enum logic [1:0] {IDLE, BODY, ESCAPE} state_t;
endpackage

// File: rtl/soundweb_unescape.sv
// soundweb_unescape: classifies rx_data/rx_valid as STX/ETX/ESC or payload and removes the escape offset when in_escape is set
module soundweb_unescape
  import soundweb_pkg::*;
(
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       in_escape,
  output logic [7:0] ub,
  output logic       ub_valid,
  output logic       is_stx,
  output logic       is_etx,
  output logic       is_esc,
  output logic       escape_error
);
  assign ub = in_escape ? rx_data - ESC_OFFSET : rx_data;
  assign is_stx = rx_valid && rx_data == STX;
  assign is_etx = rx_valid && rx_data == ETX;
  assign is_esc = rx_valid && !in_escape && rx_data == ESC;
  assign ub_valid = rx_valid && !is_stx && !is_etx && !is_esc;
  assign escape_error = in_escape && (is_stx || is_etx);
endmodule

// File: rtl/soundweb_decoder.sv
// soundweb_decoder: Soundweb London packet decoder; rx_data/rx_valid byte stream in, registered command/address/sv/data fields plus one-cycle packet_valid, checksum_error, framing_error, ack_seen, nak_seen pulses out
module soundweb_decoder
  import soundweb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] command,
  output logic [7:0] address_0,
  output logic [7:0] address_1,
  output logic [7:0] address_2,
  output logic [7:0] address_3,
  output logic [7:0] address_4,
  output logic [7:0] address_5,
  output logic [7:0] sv_0,
  output logic [7:0] sv_1,
  output logic [7:0] data_0,
  output logic [7:0] data_1,
  output logic [7:0] data_2,
  output logic [7:0] data_3,
  output logic       packet_valid,
  output logic       checksum_error,
  output logic       framing_error,
  output logic       ack_seen,
  output logic       nak_seen
);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] IMAX = TW'(TIMEOUT_CYCLES);
  state_t state, state_n;
  logic [3:0] count;
  logic [7:0] acc;
  logic [TW-1:0] idle;
  logic [BODY_LEN-1:0][7:0] stg, fld;
  logic [7:0] ub;
  logic ub_valid, is_stx, is_etx, is_esc, escape_error, tmo_hit;
  logic clr, store, ev_valid, ev_cksum, ev_frame, ev_ack, ev_nak;
  soundweb_unescape u_unescape (
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .in_escape(state == ESCAPE),
    .ub(ub),
    .ub_valid(ub_valid),
    .is_stx(is_stx),
    .is_etx(is_etx),
    .is_esc(is_esc),
    .escape_error(escape_error)
  );
  assign tmo_hit = TIMEOUT_CYCLES != 0 && int'(idle) + 1 >= TIMEOUT_CYCLES;
  assign {data_3, data_2, data_1, data_0, sv_1, sv_0, address_5, address_4,
          address_3, address_2, address_1, address_0, command} = fld;
  always_comb begin
    state_n = state;
    clr = 1'b0;
    store = 1'b0;
    ev_valid = 1'b0;
    ev_cksum = 1'b0;
    ev_frame = 1'b0;
    ev_ack = 1'b0;
    ev_nak = 1'b0;
    if (state == IDLE) begin
      state_n = is_stx ? BODY : IDLE;
      clr = is_stx;
      ev_ack = rx_valid && rx_data == ACK;
      ev_nak = rx_valid && rx_data == NAK;
    end else if (!rx_valid) begin
      state_n = tmo_hit ? IDLE : state;
      ev_frame = tmo_hit;
    end else if (is_stx) begin
      state_n = BODY;
      clr = 1'b1;
      ev_frame = escape_error;
    end else if (is_etx) begin
      state_n = IDLE;
      ev_frame = escape_error || count != 4'(PKT_LEN);
      ev_valid = !ev_frame && acc == 8'h00;
      ev_cksum = !ev_frame && acc != 8'h00;
    end else if (is_esc) begin
      state_n = ESCAPE;
    end else if (count == 4'(PKT_LEN)) begin
      state_n = IDLE;
      ev_frame = 1'b1;
    end else begin
      state_n = BODY;
      store = ub_valid;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      acc <= '0;
      idle <= '0;
      stg <= '0;
      fld <= '0;
      packet_valid <= 1'b0;
      checksum_error <= 1'b0;
      framing_error <= 1'b0;
      ack_seen <= 1'b0;
      nak_seen <= 1'b0;
    end else begin
      state <= state_n;
      packet_valid <= ev_valid;
      checksum_error <= ev_cksum;
      framing_error <= ev_frame;
      ack_seen <= ev_ack;
      nak_seen <= ev_nak;
      count <= clr ? '0 : store ? count + 1'b1 : count;
      acc <= clr ? '0 : store ? acc ^ ub : acc;
      idle <= (state == IDLE || rx_valid) ? '0 : idle == IMAX ? idle : idle + 1'b1;
      if (store && count < 4'(BODY_LEN)) stg[count] <= ub;
      if (ev_valid) fld <= stg;
    end
  end
endmodule

// File: tb/tb_soundweb_decoder.sv
// tb_soundweb_decoder: scoreboard bench driving directed byte streams and checking every decoder pulse and field set
module tb_soundweb_decoder;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    int kind;
    logic [12:0][7:0] f;
    int due;
  } ev_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic [7:0] command, address_0, address_1, address_2, address_3, address_4, address_5;
  logic [7:0] sv_0, sv_1, data_0, data_1, data_2, data_3;
  logic packet_valid, checksum_error, framing_error, ack_seen, nak_seen;
  logic [12:0][7:0] got, model, f1, f2;
  logic [4:0] pulses;
  ev_t sb[$];
  ev_t e;
  int cyc = 0;
  int checks = 0;
  int errs = 0;
  int kind;
  bq_t g, g2, gb, tmp;
  soundweb_decoder #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .command(command), .address_0(address_0), .address_1(address_1), .address_2(address_2),
    .address_3(address_3), .address_4(address_4), .address_5(address_5),
    .sv_0(sv_0), .sv_1(sv_1), .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .packet_valid(packet_valid), .checksum_error(checksum_error), .framing_error(framing_error),
    .ack_seen(ack_seen), .nak_seen(nak_seen)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign got = {data_3, data_2, data_1, data_0, sv_1, sv_0, address_5, address_4,
                address_3, address_2, address_1, address_0, command};
  assign pulses = {nak_seen, ack_seen, framing_error, checksum_error, packet_valid};
  always @(negedge clk) begin
    if (reset_n && pulses != 5'b0) begin
      checks++;
      if ($countones(pulses) != 1) begin
        errs++;
        $display("FAIL onehot: pulses=%b at cycle %0d, required exactly one", pulses, cyc);
      end else if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected: pulses=%b at cycle %0d, required none", pulses, cyc);
      end else begin
        kind = $clog2(pulses);
        e = sb.pop_front();
        if (e.kind != kind || e.f != got || e.due != cyc) begin
          errs++;
          $display("FAIL event: got kind=%0d cycle=%0d fields=%h, required kind=%0d cycle=%0d fields=%h",
                   kind, cyc, got, e.kind, e.due, e.f);
        end
      end
    end
  end
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask
  task automatic send(input bq_t q);
    foreach (q[i]) put(q[i]);
  endtask
  task automatic exp_ev(input int k, input int off);
    ev_t x;
    x.kind = k;
    x.f = model;
    x.due = cyc + off;
    sb.push_back(x);
  endtask
  task automatic check_quiet(input string name);
    checks++;
    if (got != '0 || pulses != 5'b0) begin
      errs++;
      $display("FAIL %s: fields=%h pulses=%b, required fields=0 pulses=0", name, got, pulses);
    end
  endtask
  initial begin
    g = {8'h02, 8'h8D, 8'h10, 8'h01, 8'h1B, 8'h83, 8'h00, 8'h01, 8'h37,
         8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'hCD, 8'h03};
    g2 = g;
    g2[14] = 8'h06;
    g2[15] = 8'hCB;
    gb = g;
    gb[15] = 8'hCC;
    f1 = {8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h37, 8'h01, 8'h00, 8'h03, 8'h01, 8'h10, 8'h8D};
    f2 = f1;
    f2[12] = 8'h06;
    model = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset_state");
    reset_n = 1'b1;
    send(g);
    model = f1;
    exp_ev(0, 1);
    send(gb);
    exp_ev(1, 1);
    tmp = {8'h02};
    for (int i = 0; i < 12; i++) tmp.push_back(8'h11);
    tmp.push_back(8'h03);
    send(tmp);
    exp_ev(2, 1);
    tmp = {8'h02};
    for (int i = 0; i < 15; i++) tmp.push_back(8'h11);
    send(tmp);
    exp_ev(2, 1);
    send(g2);
    model = f2;
    exp_ev(0, 1);
    put(8'h06);
    exp_ev(3, 1);
    put(8'h15);
    exp_ev(4, 1);
    tmp = {8'h02, 8'h8D, 8'h1B, 8'h03};
    send(tmp);
    exp_ev(2, 1);
    tmp = {8'h02, 8'h8D, 8'h10};
    send(tmp);
    send(g);
    model = f1;
    exp_ev(0, 1);
    send(g2);
    model = f2;
    exp_ev(0, 1);
    send(g);
    model = f1;
    exp_ev(0, 1);
    tmp = {8'h02, 8'h8D};
    send(tmp);
    exp_ev(2, 9);
    idle(20);
    tmp = {8'h02, 8'h8D, 8'h10};
    send(tmp);
    @(negedge clk);
    rx_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_quiet("reset_mid_packet");
    model = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset_hold");
    reset_n = 1'b1;
    send(gb);
    exp_ev(1, 1);
    send(g);
    model = f1;
    exp_ev(0, 1);
    idle(10);
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL missing_events: %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
